// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit paths.
package uart_pkg;

  localparam int unsigned OS_DEFAULT = 16;
  localparam int unsigned OS_HALF    = OS_DEFAULT / 2 - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side and line-side signals of the UART receiver.
interface uart_receiver_if #(
  parameter int unsigned M = 8
) ();

  logic         RxC;
  logic         RxD;
  logic         rd;
  logic [M-1:0] dout;
  logic         RF;
  logic         FE;
  logic         OE;

  modport master (
    output RxC, RxD, rd,
    input  dout, RF, FE, OE
  );

  modport slave (
    input  RxC, RxD, rd,
    output dout, RF, FE, OE
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs that idle high.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start detection, mid-bit data sampling, stop check,
// and a single-byte receive data register with full / framing / overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned M  = 8,
  parameter int unsigned N  = 3,
  parameter int unsigned OS = OS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int unsigned SW = $clog2(OS);
  localparam int unsigned BW = N + 1;

  localparam logic [SW-1:0] SCNT_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OS - 1);
  localparam logic [N:0]    BIT_LAST  = BW'(M - 1);

  rx_state_t    state;
  logic [SW-1:0] scnt;
  logic [N:0]   bitcnt;
  logic [M-1:0] shreg;
  logic [M-1:0] rdr;
  logic         rf;
  logic         fe;
  logic         oe;
  logic         rxd_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.RxD),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      scnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      rdr    <= '0;
      rf     <= 1'b0;
      fe     <= 1'b0;
      oe     <= 1'b0;
    end else begin
      // Flag clear first so a same-edge completion below overrides it.
      if (bus.rd) begin
        rf <= 1'b0;
        fe <= 1'b0;
        oe <= 1'b0;
      end
      if (bus.RxC) begin
        unique case (state)
          IDLE: begin
            if (!rxd_s) begin
              state <= START;
              scnt  <= '0;
            end
          end
          START: begin
            scnt <= scnt + 1'b1;
            if (scnt == SCNT_HALF) begin
              scnt   <= '0;
              bitcnt <= '0;
              state  <= rxd_s ? IDLE : DATA;
            end
          end
          DATA: begin
            scnt <= scnt + 1'b1;
            if (scnt == SCNT_LAST) begin
              shreg  <= {rxd_s, shreg[M-1:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == BIT_LAST) state <= STOP;
            end
          end
          STOP: begin
            scnt <= scnt + 1'b1;
            if (scnt == SCNT_LAST) begin
              if (!rxd_s) fe <= 1'b1;
              // An unread byte is kept; the new one is dropped and flagged.
              if (rf && !bus.rd) begin
                oe <= 1'b1;
              end else begin
                rdr <= shreg;
                rf  <= 1'b1;
              end
              state <= rxd_s ? IDLE : BRK;
            end
          end
          BRK: begin
            if (rxd_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout = rdr;
  assign bus.RF   = rf;
  assign bus.FE   = fe;
  assign bus.OE   = oe;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench: frame-level reference model plus directed and random frames.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int M   = 8;
  localparam int OS  = 16;
  localparam int CPT = 4;

  logic clk = 1'b0;
  logic reset;

  uart_receiver_if #(.M(M)) bus ();

  uart_receiver #(.M(M), .N(3), .OS(OS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // One RxC pulse every CPT clocks.
  int div = 0;
  initial begin
    bus.RxC = 1'b0;
    forever begin
      @(negedge clk);
      bus.RxC = (div == CPT - 1);
      div = (div + 1) % CPT;
    end
  end

  // Reference model: line sampled per tick, frames located by absolute tick arithmetic.
  logic         hist [0:32767];
  int           tk = 0;
  int           t0 = 0;
  int           armed = 0;
  bit           pend = 0;
  bit           brk = 0;
  logic         d1 = 1'b1;
  logic         d2 = 1'b1;
  logic [M-1:0] m_dout = '0;
  bit           m_rf = 0;
  bit           m_fe = 0;
  bit           m_oe = 0;

  always @(posedge clk) begin
    bit           comp;
    logic [M-1:0] cbyte;
    logic         cstop;
    logic         s;
    comp  = 0;
    cbyte = '0;
    cstop = 1'b1;
    if (reset) begin
      d1 = 1'b1; d2 = 1'b1;
      pend = 0; brk = 0; armed = tk + 1;
      m_dout = '0; m_rf = 0; m_fe = 0; m_oe = 0;
    end else begin
      s  = d2;
      d2 = d1;
      d1 = bus.RxD;
      if (bus.RxC) begin
        tk++;
        hist[tk] = s;
        if (!pend) begin
          if (brk) begin
            if (s) begin brk = 0; armed = tk + 1; end
          end else if (tk >= armed && !s) begin
            pend = 1; t0 = tk;
          end
        end else if (tk == t0 + OS / 2) begin
          if (s) begin pend = 0; armed = tk + 1; end
        end else if (tk == t0 + OS / 2 + OS * (M + 1)) begin
          comp  = 1;
          cstop = s;
          for (int i = 0; i < M; i++) cbyte[i] = hist[t0 + OS / 2 + OS * (i + 1)];
          pend = 0;
          if (s) armed = tk + 1;
          else brk = 1;
        end
      end
      if (comp) begin
        if (bus.rd) begin
          m_dout = cbyte; m_rf = 1; m_oe = 0; m_fe = !cstop;
        end else if (!m_rf) begin
          m_dout = cbyte; m_rf = 1;
          if (!cstop) m_fe = 1;
        end else begin
          m_oe = 1;
          if (!cstop) m_fe = 1;
        end
      end else if (bus.rd) begin
        m_rf = 0; m_fe = 0; m_oe = 0;
      end
    end
  end

  bit rf_prev = 0;
  int rf_rise_tk = 0;

  always @(posedge clk) begin
    #1;
    checks++;
    if ({bus.dout, bus.RF, bus.FE, bus.OE} !== {m_dout, m_rf, m_fe, m_oe}) begin
      fails++;
      $display("FAIL cycle_compare t=%0t: dout=%h RF=%b FE=%b OE=%b, required dout=%h RF=%b FE=%b OE=%b",
               $time, bus.dout, bus.RF, bus.FE, bus.OE, m_dout, m_rf, m_fe, m_oe);
    end
    if (bus.RF && !rf_prev) rf_rise_tk = tk;
    rf_prev = bus.RF;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!bus.RxC) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    bus.RxD = v;
    wait_ticks(n);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  int start_tk = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_at_stop,
                            input int abort_bit);
    @(negedge clk);
    bus.RxD  = 1'b0;
    start_tk = tk;
    wait_ticks(OS);
    for (int i = 0; i < M; i++) begin
      if (i == abort_bit) begin
        @(negedge clk);
        bus.RxD = b[i];
        wait_ticks(OS / 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_dout", 32'(bus.dout), 32'h0);
        check("reset_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'h0);
        repeat (2) @(negedge clk);
        bus.RxD = 1'b1;
        reset   = 1'b0;
        return;
      end
      drive_bit(b[i], OS);
    end
    if (rd_at_stop) begin
      @(negedge clk);
      bus.RxD = stop;
      wait_ticks(OS / 2);
      // Land rd on the clk edge of the stop-bit sample tick.
      repeat (CPT - 1) @(posedge clk);
      @(negedge clk);
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      wait_ticks(OS / 2 - 1);
    end else begin
      drive_bit(stop, OS);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    int         rdmode;
    bus.RxD = 1'b1;
    bus.rd  = 1'b0;
    reset   = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("por_dout", 32'(bus.dout), 32'h0);
    check("por_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'h0);
    idle(4);

    // Single clean frame; stop sample lands 153 ticks after the start-bit drive tick.
    send_frame(8'hA5, 1'b1, 0, -1);
    idle(4);
    check("a5_dout", 32'(bus.dout), 32'hA5);
    check("a5_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'b100);
    check("a5_latency", 32'(rf_rise_tk - start_tk), 32'd153);
    pulse_rd();
    check("a5_rd_clear", 32'(bus.RF), 32'h0);

    // Short low pulse must not start a frame.
    idle(2);
    drive_bit(1'b0, 6);
    idle(20);
    check("glitch_rf", 32'(bus.RF), 32'h0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    send_frame(8'h3C, 1'b1, 0, -1);
    idle(4);
    check("3c_dout", 32'(bus.dout), 32'h3C);
    check("3c_rf", 32'(bus.RF), 32'h1);
    pulse_rd();

    // Framing error followed by a held-low line.
    send_frame(8'h5A, 1'b0, 0, -1);
    drive_bit(1'b0, 3 * OS);
    check("fe_dout", 32'(bus.dout), 32'h5A);
    check("fe_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'b110);
    check("fe_brk_state", 32'(dut.state), 32'(BRK));
    idle(OS);
    pulse_rd();
    check("fe_rd_clear", 32'({bus.RF, bus.FE, bus.OE}), 32'h0);

    // Overrun.
    send_frame(8'h11, 1'b1, 0, -1);
    idle(2);
    send_frame(8'h22, 1'b1, 0, -1);
    idle(4);
    check("oe_dout", 32'(bus.dout), 32'h11);
    check("oe_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'b101);
    pulse_rd();
    check("oe_rd_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'h0);
    check("oe_rd_dout", 32'(bus.dout), 32'h11);

    // rd coincident with completion: completion wins.
    send_frame(8'h11, 1'b1, 0, -1);
    idle(2);
    send_frame(8'h22, 1'b1, 1, -1);
    idle(2);
    check("rdwin_dout", 32'(bus.dout), 32'h22);
    check("rdwin_flags", 32'({bus.RF, bus.FE, bus.OE}), 32'b100);

    // Reset during data bit 4, then a full frame.
    send_frame(8'h77, 1'b1, 0, 4);
    idle(4);
    send_frame(8'hFF, 1'b1, 0, -1);
    idle(4);
    check("ff_dout", 32'(bus.dout), 32'hFF);
    check("ff_rf", 32'(bus.RF), 32'h1);

    // Random frames, glitches, breaks and read timing.
    for (int n = 0; n < 24; n++) begin
      b      = 8'($urandom);
      stop   = ($urandom % 6) != 0;
      rdmode = int'($urandom % 3);
      if (rdmode == 1) pulse_rd();
      if ($urandom % 4 == 0) begin
        drive_bit(1'b0, int'($urandom_range(1, 7)));
        idle(10);
      end
      send_frame(b, stop, rdmode == 2, -1);
      if (!stop) drive_bit(1'b0, int'($urandom_range(0, 2 * OS)));
      idle(int'($urandom_range(1, 20)));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
